mem_arbiter: RTL and testbench

- Shares the single memory bus port between instruction fetch and the load/store exec unit.
- Accepts one request at a time and holds the winning requester's payload on the bus until accepted.
- Waits for the response and routes it back to the owner; at most one transaction is outstanding.
- Sits between the fetch/LSU request–response pairs and the top-level memory bus interface.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 11 +
 rtl/mem_arbiter_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/LSU memory arbiter: request payload, response word,
// arbiter state and owner encodings.
package mem_arbiter_pkg;

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] d;
  } mem_req_t;

  typedef logic [31:0] mtrans_t;

  localparam int unsigned REQ_W  = $bits(mem_req_t);
  localparam int unsigned RESP_W = $bits(mtrans_t);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWNER_IF,
    OWNER_LS
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Decoupled valid/ready channel carrying a W-bit payload.
interface mem_arbiter_if #(
  parameter int unsigned W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant selection between fetch and LSU, with starvation override.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter bit LSU_PRIO = 1'b1
) (
  input  logic       if_valid,
  input  logic       ls_valid,
  input  logic       starve_max,
  output logic       any_valid,
  output arb_owner_t grant,
  output logic       starve_inc
);

  logic pref_v;
  logic other_v;
  logic take_pref;

  always_comb begin
    pref_v    = LSU_PRIO ? ls_valid : if_valid;
    other_v   = LSU_PRIO ? if_valid : ls_valid;
    any_valid = if_valid | ls_valid;
    // the preferred side yields only when both want the bus and the cap is hit
    take_pref  = pref_v && !(other_v && starve_max);
    starve_inc = take_pref && other_v;
    if (take_pref == LSU_PRIO) grant = OWNER_LS;
    else                       grant = OWNER_IF;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory bus between fetch and LSU; one transaction outstanding,
// request held on the bus until accepted, response routed back to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit          LSU_PRIO   = 1'b1,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  if_req,
  mem_arbiter_if.master if_resp,
  mem_arbiter_if.slave  ls_req,
  mem_arbiter_if.master ls_resp,
  mem_arbiter_if.master bus_req,
  mem_arbiter_if.slave  bus_resp,
  output logic          busy
);

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic [3:0] starve_q, starve_d;

  logic       any_valid;
  logic       starve_inc;
  logic       starve_max;
  logic       resp_rdy;
  arb_owner_t grant;

  always_comb starve_max = (starve_q == STARVE_MAX);

  arb_pick #(.LSU_PRIO(LSU_PRIO)) u_pick (
    .if_valid   (if_req.valid),
    .ls_valid   (ls_req.valid),
    .starve_max (starve_max),
    .any_valid  (any_valid),
    .grant      (grant),
    .starve_inc (starve_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWNER_IF;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    resp_rdy = (owner_q == OWNER_LS) ? ls_resp.ready : if_resp.ready;
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          state_d = ARB_REQ;
          owner_d = grant;
          if (!starve_inc)                 starve_d = '0;
          else if (starve_q < STARVE_MAX)  starve_d = starve_q + 4'd1;
        end
      end
      ARB_REQ:  if (bus_req.ready) state_d = ARB_RESP;
      ARB_RESP: if (bus_resp.valid && resp_rdy) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus_req.valid  = 1'b0;
    bus_req.data   = '0;
    if_req.ready   = 1'b0;
    ls_req.ready   = 1'b0;
    if_resp.valid  = 1'b0;
    if_resp.data   = '0;
    ls_resp.valid  = 1'b0;
    ls_resp.data   = '0;
    bus_resp.ready = 1'b0;
    busy           = (state_q != ARB_IDLE);
    unique case (state_q)
      ARB_REQ: begin
        bus_req.valid = 1'b1;
        if (owner_q == OWNER_LS) begin
          bus_req.data = ls_req.data;
          ls_req.ready = bus_req.ready;
        end else begin
          bus_req.data = if_req.data;
          if_req.ready = bus_req.ready;
        end
      end
      ARB_RESP: begin
        bus_resp.ready = resp_rdy;
        if (owner_q == OWNER_LS) begin
          ls_resp.valid = bus_resp.valid;
          ls_resp.data  = bus_resp.data;
        end else begin
          if_resp.valid = bus_resp.valid;
          if_resp.data  = bus_resp.data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle,
// plus literal expectations for latency, ordering, backpressure and reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam bit          LSU_PRIO   = 1'b1;
  localparam int unsigned MAX_STARVE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  mem_arbiter_if #(.W(REQ_W))  if_req_i ();
  mem_arbiter_if #(.W(RESP_W)) if_resp_i ();
  mem_arbiter_if #(.W(REQ_W))  ls_req_i ();
  mem_arbiter_if #(.W(RESP_W)) ls_resp_i ();
  mem_arbiter_if #(.W(REQ_W))  bus_req_i ();
  mem_arbiter_if #(.W(RESP_W)) bus_resp_i ();

  mem_arbiter #(.LSU_PRIO(LSU_PRIO), .MAX_STARVE(MAX_STARVE)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req_i),
    .if_resp  (if_resp_i),
    .ls_req   (ls_req_i),
    .ls_resp  (ls_resp_i),
    .bus_req  (bus_req_i),
    .bus_resp (bus_resp_i),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mem_req_t mk(input logic [31:0] a, input logic we,
                                  input logic [3:0] be, input logic [31:0] d);
    mem_req_t r;
    r.a = a; r.we = we; r.be = be; r.d = d;
    return r;
  endfunction

  // Model: owner 0 = none, 1 = fetch, 2 = LSU; acc = bus has taken the request.
  int m_own = 0, n_own = 0;
  bit m_acc = 0, n_acc = 0;
  int m_starve = 0, n_starve = 0;
  bit mdl_log[$];
  bit dut_log[$];

  bit e_req, e_rsp, e_busy, e_if_rdy, e_ls_rdy, e_if_rv, e_ls_rv, e_brr;
  bit if_hs, ls_hs, breq_hs, bresp_hs;
  int busy_cnt, if_rv_cnt, ls_rv_cnt, if_rdy_cnt, ls_rdy_cnt, bus_v_cnt, bus_bad, rsp_stall, brr_cnt;
  logic [31:0] if_rx, ls_rx;
  logic [68:0] bp_exp;

  always @(negedge clk) begin
    e_busy   = (m_own != 0);
    e_req    = e_busy && !m_acc;
    e_rsp    = e_busy && m_acc;
    e_if_rdy = e_req && m_own == 1 && bus_req_i.ready;
    e_ls_rdy = e_req && m_own == 2 && bus_req_i.ready;
    e_if_rv  = e_rsp && m_own == 1 && bus_resp_i.valid;
    e_ls_rv  = e_rsp && m_own == 2 && bus_resp_i.valid;
    e_brr    = e_rsp && ((m_own == 1) ? if_resp_i.ready : ls_resp_i.ready);

    chk("busy", busy, e_busy);
    chk("bus_req.valid", bus_req_i.valid, e_req);
    if (e_req) chk("bus_req.data", bus_req_i.data, (m_own == 2) ? ls_req_i.data : if_req_i.data);
    chk("if_req.ready", if_req_i.ready, e_if_rdy);
    chk("ls_req.ready", ls_req_i.ready, e_ls_rdy);
    chk("if_resp.valid", if_resp_i.valid, e_if_rv);
    chk("ls_resp.valid", ls_resp_i.valid, e_ls_rv);
    chk("bus_resp.ready", bus_resp_i.ready, e_brr);
    if (e_if_rv) chk("if_resp.data", if_resp_i.data, bus_resp_i.data);
    if (e_ls_rv) chk("ls_resp.data", ls_resp_i.data, bus_resp_i.data);

    if_hs    = if_req_i.valid && if_req_i.ready;
    ls_hs    = ls_req_i.valid && ls_req_i.ready;
    breq_hs  = bus_req_i.valid && bus_req_i.ready;
    bresp_hs = bus_resp_i.valid && bus_resp_i.ready;
    if (if_hs) dut_log.push_back(1'b0);
    if (ls_hs) dut_log.push_back(1'b1);
    if (busy) busy_cnt++;
    if (if_resp_i.valid) if_rv_cnt++;
    if (ls_resp_i.valid) ls_rv_cnt++;
    if (if_req_i.ready) if_rdy_cnt++;
    if (ls_req_i.ready) ls_rdy_cnt++;
    if (bus_req_i.valid) bus_v_cnt++;
    if (bus_req_i.valid && bus_req_i.data !== bp_exp) bus_bad++;
    if (bus_resp_i.valid && !bus_resp_i.ready) rsp_stall++;
    if (bus_resp_i.ready) brr_cnt++;
    if (if_resp_i.valid && if_resp_i.ready) if_rx = if_resp_i.data;
    if (ls_resp_i.valid && ls_resp_i.ready) ls_rx = ls_resp_i.data;

    n_own = m_own; n_acc = m_acc; n_starve = m_starve;
    if (rst) begin
      n_own = 0; n_acc = 0; n_starve = 0;
    end else if (m_own == 0) begin
      if (if_req_i.valid || ls_req_i.valid) begin
        int pref, other, win;
        pref  = LSU_PRIO ? 2 : 1;
        other = 3 - pref;
        if (if_req_i.valid && ls_req_i.valid)
          win = (m_starve == MAX_STARVE) ? other : pref;
        else
          win = if_req_i.valid ? 1 : 2;
        if (win == pref && if_req_i.valid && ls_req_i.valid)
          n_starve = (m_starve < MAX_STARVE) ? m_starve + 1 : m_starve;
        else
          n_starve = 0;
        n_own = win;
        mdl_log.push_back(win == 2);
      end
    end else if (!m_acc) begin
      if (bus_req_i.ready) n_acc = 1;
    end else if (bus_resp_i.valid && ((m_own == 1) ? if_resp_i.ready : ls_resp_i.ready)) begin
      n_own = 0; n_acc = 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own <= 0; m_acc <= 0; m_starve <= 0;
    end else begin
      m_own <= n_own; m_acc <= n_acc; m_starve <= n_starve;
    end
  end

  bit ls_keep = 0, if_keep = 0, mem_auto = 1;
  int seq = 0;
  logic [31:0] rsp_data = '0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (ls_hs) begin
      if (ls_keep) begin seq++; ls_req_i.data = mk(32'h1000 + 32'(seq), 1'b0, 4'hF, '0); end
      else ls_req_i.valid = 1'b0;
    end
    if (if_hs) begin
      if (if_keep) begin seq++; if_req_i.data = mk(32'h2000 + 32'(seq), 1'b0, 4'hF, '0); end
      else if_req_i.valid = 1'b0;
    end
    if (mem_auto) begin
      if (bresp_hs) bus_resp_i.valid = 1'b0;
      if (breq_hs) begin bus_resp_i.valid = 1'b1; bus_resp_i.data = rsp_data; end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || if_req_i.valid || ls_req_i.valid || bus_resp_i.valid) && n < 80) begin
      cyc(); n++;
    end
    chk({name, "_completes"}, n < 80, 1'b1);
  endtask

  task automatic wait_log(input int cnt, input string name);
    int n = 0;
    while (dut_log.size() < cnt && n < 200) begin cyc(); n++; end
    chk({name, "_grants_seen"}, n < 200, 1'b1);
  endtask

  function automatic logic [15:0] pack(input int cnt, input bit q[$]);
    logic [15:0] v = '0;
    for (int i = 0; i < cnt && i < q.size(); i++) v[i] = q[i];
    return v;
  endfunction

  task automatic clr();
    busy_cnt = 0; if_rv_cnt = 0; ls_rv_cnt = 0; if_rdy_cnt = 0; ls_rdy_cnt = 0;
    bus_v_cnt = 0; bus_bad = 0; rsp_stall = 0; brr_cnt = 0; if_rx = '0; ls_rx = '0;
    dut_log.delete(); mdl_log.delete();
  endtask

  initial begin
    if_req_i.valid = 0; if_req_i.data = '0; ls_req_i.valid = 0; ls_req_i.data = '0;
    if_resp_i.ready = 1; ls_resp_i.ready = 1; bus_req_i.ready = 1;
    bus_resp_i.valid = 0; bus_resp_i.data = '0; bp_exp = '0;
    clr();
    #1;
    chk("reset_outputs", {busy, bus_req_i.valid, bus_resp_i.ready, if_req_i.ready,
                          ls_req_i.ready, if_resp_i.valid, ls_resp_i.valid}, '0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    cyc();

    // single LSU load
    clr(); rsp_data = 32'hDEADBEEF;
    ls_req_i.data = mk(32'h100, 1'b0, 4'hF, '0); ls_req_i.valid = 1;
    wait_idle("load");
    chk("load_busy_cycles", busy_cnt, 2);
    chk("load_ls_data", ls_rx, 32'hDEADBEEF);
    chk("load_if_resp_quiet", if_rv_cnt, 0);

    // simultaneous requests: LSU first, then fetch
    clr(); rsp_data = 32'h11112222;
    if_req_i.data = mk(32'h0, 1'b0, 4'hF, '0);   if_req_i.valid = 1;
    ls_req_i.data = mk(32'h200, 1'b0, 4'hF, '0); ls_req_i.valid = 1;
    wait_idle("simul");
    chk("simul_order", {dut_log.size() == 2, pack(2, dut_log)}, {1'b1, 16'h0001});

    // starvation cap: LS x4 then IF, repeating
    clr(); if_keep = 1; ls_keep = 1;
    if_req_i.data = mk(32'h2000, 1'b0, 4'hF, '0); if_req_i.valid = 1;
    ls_req_i.data = mk(32'h1000, 1'b0, 4'hF, '0); ls_req_i.valid = 1;
    wait_log(10, "starve");
    if_keep = 0; ls_keep = 0;
    wait_idle("starve");
    chk("starve_order_dut", pack(10, dut_log), 16'h01EF);
    chk("starve_order_model", pack(10, mdl_log), 16'h01EF);

    // bus request backpressure on a fetch write
    clr(); rsp_data = 32'h0;
    bp_exp = mk(32'h300, 1'b1, 4'h4, 32'h00AB0000);
    if_req_i.data = bp_exp; if_req_i.valid = 1; bus_req_i.ready = 0;
    repeat (6) cyc();
    bus_req_i.ready = 1;
    wait_idle("bp");
    chk("bp_valid_cycles", bus_v_cnt, 6);
    chk("bp_payload_stable", bus_bad, 0);
    chk("bp_ready_pulses", if_rdy_cnt, 1);
    bp_exp = '0;

    // response backpressure from fetch
    clr(); rsp_data = 32'h5555AAAA; if_resp_i.ready = 0;
    if_req_i.data = mk(32'h40, 1'b0, 4'hF, '0); if_req_i.valid = 1;
    repeat (5) cyc();
    if_resp_i.ready = 1;
    wait_idle("rbp");
    chk("rbp_stall_cycles", rsp_stall, 3);
    chk("rbp_busy_cycles", busy_cnt, 5);
    chk("rbp_if_data", if_rx, 32'h5555AAAA);

    // stray response while idle
    clr(); mem_auto = 0;
    bus_resp_i.data = 32'h1234; bus_resp_i.valid = 1;
    repeat (3) cyc();
    bus_resp_i.valid = 0; mem_auto = 1;
    chk("stray_no_resp_valid", if_rv_cnt + ls_rv_cnt, 0);
    chk("stray_no_bus_ready", brr_cnt, 0);
    chk("stray_not_busy", busy_cnt, 0);

    // reset during RESP with starve_cnt at 3
    clr(); rsp_data = 32'h77778888; if_keep = 1; ls_keep = 1;
    if_req_i.data = mk(32'h2000, 1'b0, 4'hF, '0); if_req_i.valid = 1;
    ls_req_i.data = mk(32'h1000, 1'b0, 4'hF, '0); ls_req_i.valid = 1;
    wait_log(3, "rst_pre");
    #2 rst = 1;
    #1;
    chk("rst_outputs_drop", {busy, bus_req_i.valid, bus_resp_i.ready, if_req_i.ready,
                             ls_req_i.ready, if_resp_i.valid, ls_resp_i.valid}, '0);
    if_keep = 0; ls_keep = 0; if_req_i.valid = 0; ls_req_i.valid = 0; bus_resp_i.valid = 0;
    @(posedge clk); @(posedge clk); #1 rst = 0;
    clr(); rsp_data = 32'hCAFEF00D;
    if_req_i.data = mk(32'h600, 1'b0, 4'hF, '0); if_req_i.valid = 1;
    wait_idle("post_rst");
    chk("post_rst_if_data", if_rx, 32'hCAFEF00D);
    clr(); if_keep = 1; ls_keep = 1;
    if_req_i.data = mk(32'h2000, 1'b0, 4'hF, '0); if_req_i.valid = 1;
    ls_req_i.data = mk(32'h1000, 1'b0, 4'hF, '0); ls_req_i.valid = 1;
    wait_log(5, "post_rst_starve");
    if_keep = 0; ls_keep = 0;
    wait_idle("post_rst_starve");
    chk("post_rst_starve_order", pack(5, dut_log), 16'h000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
